// File: rtl/ysyx_25020077_ifu_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020077_ifu_if
// Purpose  : Bundles the instruction-fetch unit's memory fetch channel,
//            decode hand-off channel and control inputs (redirect and halt).
// Modports :
//   master - fetch-unit side. It drives the request, out and halted signals
//            and samples the memory response and the decode-side controls.
//   slave  - environment side. This is memory plus decode/execute.
// Signals  :
//   io_mem_req_valid/ready/addr   fetch request (addr = pc)
//   io_mem_resp_valid/data        instruction word return
//   io_out_valid/ready            instruction hand-off to decode
//   io_out_instruction/pc         held instruction and its address
//   io_redirect_valid/target      taken jump/branch target
//   io_halt / io_halted           ebreak retire / fetch frozen
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_25020077_ifu_if;
  logic        io_mem_req_valid;
  logic        io_mem_req_ready;
  logic [31:0] io_mem_req_addr;
  logic        io_mem_resp_valid;
  logic [31:0] io_mem_resp_data;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_instruction;
  logic [31:0] io_out_pc;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_target;
  logic        io_halt;
  logic        io_halted;

  modport master (
    output io_mem_req_valid,
    input  io_mem_req_ready,
    output io_mem_req_addr,
    input  io_mem_resp_valid,
    input  io_mem_resp_data,
    output io_out_valid,
    input  io_out_ready,
    output io_out_instruction,
    output io_out_pc,
    input  io_redirect_valid,
    input  io_redirect_target,
    input  io_halt,
    output io_halted
  );

  modport slave (
    input  io_mem_req_valid,
    output io_mem_req_ready,
    input  io_mem_req_addr,
    output io_mem_resp_valid,
    output io_mem_resp_data,
    input  io_out_valid,
    output io_out_ready,
    input  io_out_instruction,
    input  io_out_pc,
    output io_redirect_valid,
    output io_redirect_target,
    output io_halt,
    input  io_halted
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_25020077_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25020077_ifu
// Purpose  : Instruction fetch unit for the single-cycle core. It owns the PC
//            and keeps one fetch request to instruction memory in flight at a
//            time. It captures the returned word and offers it to decode over
//            a valid/ready handshake. On acceptance it advances the PC by +4 or
//            to a redirect target. A halt freezes fetch until reset.
// Ports    :
//   clock  - core clock, rising-edge
//   reset  - synchronous, active-high
//   bus    - ysyx_25020077_ifu_if.master (fetch, hand-off and control signals)
// Params   :
//   RESET_PC - PC loaded on reset (word aligned)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25020077_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  wire                        clock,
  input  wire                        reset,
  ysyx_25020077_ifu_if.master        bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] w_next_pc;
  logic [31:0] r_inst;
  logic [31:0] w_next_inst;

  // Decode accepts the held instruction. Redirect and halt only matter here.
  logic        w_accept;
  assign w_accept = (r_state == S_HOLD) && bus.io_out_ready;

  // Redirect targets are forced to word alignment. The low bits are dropped.
  logic        w_unused_target_lsbs;
  assign w_unused_target_lsbs = ^bus.io_redirect_target[1:0];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_inst  <= 32'h0;
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_inst  <= w_next_inst;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_inst  = r_inst;

    case (r_state)
      S_REQ: begin
        // The address is r_pc. It stays stable until memory takes the request.
        if (bus.io_mem_req_ready) begin
          w_next_state = S_WAIT;
        end
      end

      S_WAIT: begin
        // A response is consumed only here. This also discards a stale
        // response that arrives after reset abandoned a request.
        if (bus.io_mem_resp_valid) begin
          w_next_inst  = bus.io_mem_resp_data;
          w_next_state = S_HOLD;
        end
      end

      S_HOLD: begin
        if (w_accept) begin
          if (bus.io_halt) begin
            // Halt wins over a simultaneous redirect. The PC stays on the ebreak.
            w_next_state = S_HALT;
          end else if (bus.io_redirect_valid) begin
            w_next_pc    = {bus.io_redirect_target[31:2], 2'b00};
            w_next_state = S_REQ;
          end else begin
            // Natural 32-bit wrap takes 32'hFFFF_FFFC to 0.
            w_next_pc    = r_pc + 32'd4;
            w_next_state = S_REQ;
          end
        end
      end

      S_HALT: begin
        w_next_state = S_HALT;
      end

      default: begin
        w_next_state = S_REQ;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs: pure decodes of registered state (no input-to-output paths)
  // --------------------------------------------------------------------------
  assign bus.io_mem_req_valid   = (r_state == S_REQ);
  assign bus.io_mem_req_addr    = r_pc;
  assign bus.io_out_valid       = (r_state == S_HOLD);
  assign bus.io_out_instruction = r_inst;
  assign bus.io_out_pc          = r_pc;
  assign bus.io_halted          = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020077_ifu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_25020077_ifu
// Purpose  : Directed self-checking bench for ysyx_25020077_ifu. The expected
//            values below are derived by hand from the fetch protocol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25020077_ifu;

  localparam logic [31:0] C_RESET_PC = 32'h8000_0000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  ysyx_25020077_ifu_if bus ();

  ysyx_25020077_ifu #(.RESET_PC(C_RESET_PC)) u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge. Sampling and driving happen 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one full fetch starting from S_REQ. Take the request right away,
  // return the word one cycle later, and accept it with the given controls.
  task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data,
                          input logic redir, input logic [31:0] tgt, input logic hlt);
    chk("req_valid@REQ", {31'b0, bus.io_mem_req_valid}, 32'd1);
    chk("req_addr@REQ", bus.io_mem_req_addr, exp_pc);
    bus.io_mem_req_ready = 1'b1;
    step();
    bus.io_mem_req_ready = 1'b0;
    chk("req_valid@WAIT", {31'b0, bus.io_mem_req_valid}, 32'd0);
    bus.io_mem_resp_valid = 1'b1;
    bus.io_mem_resp_data  = data;
    step();
    bus.io_mem_resp_valid = 1'b0;
    chk("out_valid@HOLD", {31'b0, bus.io_out_valid}, 32'd1);
    chk("out_inst@HOLD", bus.io_out_instruction, data);
    chk("out_pc@HOLD", bus.io_out_pc, exp_pc);
    bus.io_out_ready       = 1'b1;
    bus.io_redirect_valid  = redir;
    bus.io_redirect_target = tgt;
    bus.io_halt            = hlt;
    step();
    bus.io_redirect_valid = 1'b0;
    bus.io_halt           = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.io_mem_req_ready   = 1'b0;
    bus.io_mem_resp_valid  = 1'b0;
    bus.io_mem_resp_data   = 32'h0;
    bus.io_out_ready       = 1'b0;
    bus.io_redirect_valid  = 1'b0;
    bus.io_redirect_target = 32'h0;
    bus.io_halt            = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state (cycle0)
    chk("rst_req_valid", {31'b0, bus.io_mem_req_valid}, 32'd1);
    chk("rst_req_addr", bus.io_mem_req_addr, C_RESET_PC);
    chk("rst_out_valid", {31'b0, bus.io_out_valid}, 32'd0);
    chk("rst_out_inst", bus.io_out_instruction, 32'h0);
    chk("rst_out_pc", bus.io_out_pc, C_RESET_PC);
    chk("rst_halted", {31'b0, bus.io_halted}, 32'd0);

    // Ideal memory, first instruction: cycle0 REQ, cycle1 WAIT, cycle2 HOLD
    bus.io_out_ready = 1'b1;
    do_fetch(C_RESET_PC, 32'h0010_0093, 1'b0, 32'h0, 1'b0);

    // req_ready low for 4 cycles. A stray response during REQ is ignored.
    bus.io_mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.io_mem_resp_valid = (i == 1);
      bus.io_mem_resp_data  = 32'hDEAD_BEEF;
      chk("stall_req_valid", {31'b0, bus.io_mem_req_valid}, 32'd1);
      chk("stall_req_addr", bus.io_mem_req_addr, 32'h8000_0004);
      chk("stall_out_valid", {31'b0, bus.io_out_valid}, 32'd0);
      step();
    end
    bus.io_mem_resp_valid = 1'b0;
    chk("stall_req_valid_end", {31'b0, bus.io_mem_req_valid}, 32'd1);
    bus.io_mem_req_ready = 1'b1;
    step();
    bus.io_mem_req_ready = 1'b0;
    // Response delayed 3 cycles. There is no reissue and no early out_valid.
    for (int i = 0; i < 3; i++) begin
      chk("wait_req_valid", {31'b0, bus.io_mem_req_valid}, 32'd0);
      chk("wait_out_valid", {31'b0, bus.io_out_valid}, 32'd0);
      step();
    end
    bus.io_out_ready      = 1'b0;
    bus.io_mem_resp_valid = 1'b1;
    bus.io_mem_resp_data  = 32'h0020_8113;
    step();
    bus.io_mem_resp_valid = 1'b0;

    // out_ready low for 5 cycles in HOLD. Redirect pulses are not a handshake.
    for (int i = 0; i < 5; i++) begin
      bus.io_mem_resp_valid  = (i == 2);
      bus.io_mem_resp_data   = 32'hCAFE_F00D;
      bus.io_redirect_valid  = (i == 3);
      bus.io_redirect_target = 32'h1234_5678;
      chk("hold_out_valid", {31'b0, bus.io_out_valid}, 32'd1);
      chk("hold_out_inst", bus.io_out_instruction, 32'h0020_8113);
      chk("hold_out_pc", bus.io_out_pc, 32'h8000_0004);
      chk("hold_req_valid", {31'b0, bus.io_mem_req_valid}, 32'd0);
      step();
    end
    bus.io_mem_resp_valid = 1'b0;
    // Handshake with redirect to an unaligned target.
    bus.io_out_ready       = 1'b1;
    bus.io_redirect_valid  = 1'b1;
    bus.io_redirect_target = 32'h8000_0103;
    step();
    bus.io_redirect_valid = 1'b0;

    // Redirect pulsed during WAIT is ignored.
    chk("redir_req_addr", bus.io_mem_req_addr, 32'h8000_0100);
    bus.io_mem_req_ready = 1'b1;
    step();
    bus.io_mem_req_ready   = 1'b0;
    bus.io_redirect_valid  = 1'b1;
    bus.io_redirect_target = 32'h4000_0000;
    bus.io_mem_resp_valid  = 1'b1;
    bus.io_mem_resp_data   = 32'h0000_0013;
    step();
    bus.io_mem_resp_valid = 1'b0;
    bus.io_redirect_valid = 1'b0;
    chk("wredir_out_pc", bus.io_out_pc, 32'h8000_0100);
    step();
    chk("wredir_next_addr", bus.io_mem_req_addr, 32'h8000_0104);

    // Redirect to the top word. The low bits are masked.
    do_fetch(32'h8000_0104, 32'h0000_006F, 1'b1, 32'hFFFF_FFFE, 1'b0);
    // Sequential handshake at 32'hFFFF_FFFC wraps to 0.
    do_fetch(32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr", bus.io_mem_req_addr, 32'h0000_0000);

    // Halt together with redirect. Halt wins.
    do_fetch(32'h0000_0000, 32'h0010_0073, 1'b1, 32'h8000_0200, 1'b1);
    bus.io_mem_req_ready  = 1'b1;
    bus.io_mem_resp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("halt_halted", {31'b0, bus.io_halted}, 32'd1);
      chk("halt_req_valid", {31'b0, bus.io_mem_req_valid}, 32'd0);
      chk("halt_out_valid", {31'b0, bus.io_out_valid}, 32'd0);
      chk("halt_pc", bus.io_out_pc, 32'h0000_0000);
      step();
    end
    bus.io_mem_resp_valid = 1'b0;

    // Reset restarts fetch.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rrst_halted", {31'b0, bus.io_halted}, 32'd0);
    chk("rrst_req_addr", bus.io_mem_req_addr, C_RESET_PC);
    chk("rrst_out_inst", bus.io_out_instruction, 32'h0);

    // Reset mid-request, then a stale response arrives in REQ.
    step();
    chk("mid_req_valid", {31'b0, bus.io_mem_req_valid}, 32'd0);
    bus.io_mem_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.io_mem_resp_valid = 1'b1;
    bus.io_mem_resp_data  = 32'hBAD0_BAD0;
    step();
    bus.io_mem_resp_valid = 1'b0;
    chk("stale_req_valid", {31'b0, bus.io_mem_req_valid}, 32'd1);
    chk("stale_out_valid", {31'b0, bus.io_out_valid}, 32'd0);
    chk("stale_out_inst", bus.io_out_instruction, 32'h0);
    do_fetch(C_RESET_PC, 32'h0041_0193, 1'b0, 32'h0, 1'b0);
    chk("final_addr", bus.io_mem_req_addr, 32'h8000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
